// File: rtl/cp_pi_sram_arbiter.sv
// ============================================================================
// Module      : cp_pi_sram_arbiter
// Description : Arbitrates access to the shared 64K x 8 SRAM and D bus
//               between the clock-port (CP) and Raspberry Pi (PI) register
//               decoders. One access is in flight at a time, conflicts are
//               resolved round-robin and each requester uses a 4-phase
//               req/ack handshake. All outputs are registered.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK, RST_n         clock, synchronous active-low reset
//   CP_REQ/WE/ADDR     CP request (write data arrives via the input latch)
//   CP_ACK             one-cycle completion pulse to CP
//   PI_REQ/WE/ADDR     PI request
//   PI_WDATA           PI write data
//   PI_ACK             one-cycle completion pulse to PI
//   PI_RDATA           PI read data, valid from PI_ACK until next PI read
//   D_IN               sampled D bus
//   D_OUT, D_OE        FPGA drive value / drive enable for D
//   RAM_A              SRAM address
//   RAM_OE_n, RAM_WE_n SRAM strobes
//   LE_OUT             output latch (towards CP) enable
//   OE_IN_n            input latch (CP_Data -> D) output enable
//   GRANT_PI           1 while the current/last access belongs to PI
//   BUSY               1 in any state other than IDLE
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cp_pi_sram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int RD_CYCLES = 3,
  parameter int WR_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              CP_REQ,
  input  logic              CP_WE,
  input  logic [ADDR_W-1:0] CP_ADDR,
  output logic              CP_ACK,
  input  logic              PI_REQ,
  input  logic              PI_WE,
  input  logic [ADDR_W-1:0] PI_ADDR,
  input  logic [7:0]        PI_WDATA,
  output logic              PI_ACK,
  output logic [7:0]        PI_RDATA,
  input  logic [7:0]        D_IN,
  output logic [7:0]        D_OUT,
  output logic              D_OE,
  output logic [ADDR_W-1:0] RAM_A,
  output logic              RAM_OE_n,
  output logic              RAM_WE_n,
  output logic              LE_OUT,
  output logic              OE_IN_n,
  output logic              GRANT_PI,
  output logic              BUSY
);

  localparam int C_MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic [C_CNT_W-1:0]  cnt_q,      cnt_d;
  logic                we_q,       we_d;
  logic [ADDR_W-1:0]   ram_a_q,    ram_a_d;
  logic                ram_oe_n_q, ram_oe_n_d;
  logic                ram_we_n_q, ram_we_n_d;
  logic                le_out_q,   le_out_d;
  logic                oe_in_n_q,  oe_in_n_d;
  logic                d_oe_q,     d_oe_d;
  logic [7:0]          d_out_q,    d_out_d;
  logic [7:0]          pi_rdata_q, pi_rdata_d;
  logic                cp_ack_q,   cp_ack_d;
  logic                pi_ack_q,   pi_ack_d;
  logic                grant_pi_q, grant_pi_d;
  logic                busy_q,     busy_d;
  logic                last_pi_q,  last_pi_d;
  logic                cp_armed_q, cp_armed_d;
  logic                pi_armed_q, pi_armed_d;

  logic w_cp_elig;
  logic w_pi_elig;
  logic w_pick_pi;

  // A requester is only eligible while armed, so a REQ held high after its
  // ACK cannot start a second access until it has been seen low.
  assign w_cp_elig = CP_REQ & cp_armed_q;
  assign w_pi_elig = PI_REQ & pi_armed_q;
  // PI wins when alone, or on a tie when CP was granted last.
  assign w_pick_pi = w_pi_elig & (~w_cp_elig | ~last_pi_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    ram_a_d    = ram_a_q;
    ram_oe_n_d = ram_oe_n_q;
    ram_we_n_d = ram_we_n_q;
    le_out_d   = le_out_q;
    oe_in_n_d  = oe_in_n_q;
    d_oe_d     = d_oe_q;
    d_out_d    = d_out_q;
    pi_rdata_d = pi_rdata_q;
    cp_ack_d   = 1'b0;
    pi_ack_d   = 1'b0;
    grant_pi_d = grant_pi_q;
    busy_d     = busy_q;
    last_pi_d  = last_pi_q;
    // Re-arm as soon as REQ is sampled low; the HOLD entry below clears it.
    cp_armed_d = CP_REQ ? cp_armed_q : 1'b1;
    pi_armed_d = PI_REQ ? pi_armed_q : 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (w_cp_elig || w_pi_elig) begin
          state_d    = ST_SETUP;
          busy_d     = 1'b1;
          grant_pi_d = w_pick_pi;
          last_pi_d  = w_pick_pi;
          ram_oe_n_d = 1'b1;
          ram_we_n_d = 1'b1;
          if (w_pick_pi) begin
            we_d      = PI_WE;
            ram_a_d   = PI_ADDR;
            d_out_d   = PI_WDATA;
            d_oe_d    = PI_WE;
            oe_in_n_d = 1'b1;
            le_out_d  = 1'b0;
          end else begin
            we_d      = CP_WE;
            ram_a_d   = CP_ADDR;
            d_oe_d    = 1'b0;
            oe_in_n_d = ~CP_WE;
            // Open the output latch for a CP read so it tracks the SRAM data.
            le_out_d  = ~CP_WE;
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        if (we_q) begin
          ram_we_n_d = 1'b0;
          cnt_d      = C_CNT_W'(WR_CYCLES - 1);
        end else begin
          ram_oe_n_d = 1'b0;
          cnt_d      = C_CNT_W'(RD_CYCLES - 1);
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = ST_HOLD;
          ram_oe_n_d = 1'b1;
          ram_we_n_d = 1'b1;
          // Falling LE_OUT makes the output latch keep the read data.
          le_out_d   = 1'b0;
          if (grant_pi_q) begin
            pi_ack_d   = 1'b1;
            pi_armed_d = 1'b0;
            if (!we_q) begin
              pi_rdata_d = D_IN;
            end
          end else begin
            cp_ack_d   = 1'b1;
            cp_armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // Write data was held through HOLD for SRAM hold time; release now.
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        d_oe_d    = 1'b0;
        oe_in_n_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      ram_a_q    <= '0;
      ram_oe_n_q <= 1'b1;
      ram_we_n_q <= 1'b1;
      le_out_q   <= 1'b0;
      oe_in_n_q  <= 1'b1;
      d_oe_q     <= 1'b0;
      d_out_q    <= 8'h00;
      pi_rdata_q <= 8'h00;
      cp_ack_q   <= 1'b0;
      pi_ack_q   <= 1'b0;
      grant_pi_q <= 1'b0;
      busy_q     <= 1'b0;
      last_pi_q  <= 1'b1;   // CP wins the first tie
      cp_armed_q <= 1'b1;
      pi_armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      ram_a_q    <= ram_a_d;
      ram_oe_n_q <= ram_oe_n_d;
      ram_we_n_q <= ram_we_n_d;
      le_out_q   <= le_out_d;
      oe_in_n_q  <= oe_in_n_d;
      d_oe_q     <= d_oe_d;
      d_out_q    <= d_out_d;
      pi_rdata_q <= pi_rdata_d;
      cp_ack_q   <= cp_ack_d;
      pi_ack_q   <= pi_ack_d;
      grant_pi_q <= grant_pi_d;
      busy_q     <= busy_d;
      last_pi_q  <= last_pi_d;
      cp_armed_q <= cp_armed_d;
      pi_armed_q <= pi_armed_d;
    end
  end

  assign CP_ACK   = cp_ack_q;
  assign PI_ACK   = pi_ack_q;
  assign PI_RDATA = pi_rdata_q;
  assign D_OUT    = d_out_q;
  assign D_OE     = d_oe_q;
  assign RAM_A    = ram_a_q;
  assign RAM_OE_n = ram_oe_n_q;
  assign RAM_WE_n = ram_we_n_q;
  assign LE_OUT   = le_out_q;
  assign OE_IN_n  = oe_in_n_q;
  assign GRANT_PI = grant_pi_q;
  assign BUSY     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cp_pi_sram_arbiter.sv
// ============================================================================
// Module      : tb_cp_pi_sram_arbiter
// Description : Self-checking bench for cp_pi_sram_arbiter. Models the SRAM,
//               the CP input latch and the CP output latch around the D bus;
//               a scoreboard holds expected completions per requester and a
//               negedge monitor checks them at each ACK.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cp_pi_sram_arbiter;

  localparam int ADDR_W    = 16;
  localparam int RD_CYCLES = 3;
  localparam int WR_CYCLES = 3;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              CP_REQ, CP_WE;
  logic [ADDR_W-1:0] CP_ADDR;
  logic              CP_ACK;
  logic              PI_REQ, PI_WE;
  logic [ADDR_W-1:0] PI_ADDR;
  logic [7:0]        PI_WDATA;
  logic              PI_ACK;
  logic [7:0]        PI_RDATA;
  logic [7:0]        D_IN, D_OUT;
  logic              D_OE;
  logic [ADDR_W-1:0] RAM_A;
  logic              RAM_OE_n, RAM_WE_n, LE_OUT, OE_IN_n, GRANT_PI, BUSY;

  cp_pi_sram_arbiter #(
    .ADDR_W   (ADDR_W),
    .RD_CYCLES(RD_CYCLES),
    .WR_CYCLES(WR_CYCLES)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .CP_REQ(CP_REQ), .CP_WE(CP_WE), .CP_ADDR(CP_ADDR), .CP_ACK(CP_ACK),
    .PI_REQ(PI_REQ), .PI_WE(PI_WE), .PI_ADDR(PI_ADDR), .PI_WDATA(PI_WDATA),
    .PI_ACK(PI_ACK), .PI_RDATA(PI_RDATA),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
    .RAM_A(RAM_A), .RAM_OE_n(RAM_OE_n), .RAM_WE_n(RAM_WE_n),
    .LE_OUT(LE_OUT), .OE_IN_n(OE_IN_n), .GRANT_PI(GRANT_PI), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // ---------------- board model: SRAM, input latch, output latch ----------
  logic [7:0] mem     [0:65535];   // physical SRAM
  logic [7:0] ref_mem [0:65535];   // reference model of SRAM contents
  logic [7:0] cp_data;             // value presented by the CP input latch
  logic [7:0] cp_latch;            // CP output latch
  logic [7:0] d_bus;

  assign d_bus = D_OE      ? D_OUT :
                 !OE_IN_n  ? cp_data :
                 !RAM_OE_n ? mem[RAM_A] : 8'h00;
  assign D_IN  = d_bus;

  always @(posedge CLK) begin
    if (!RAM_WE_n) mem[RAM_A] <= d_bus;
  end

  always @(negedge CLK) begin
    if (LE_OUT) cp_latch <= d_bus;
  end

  // ---------------- scoreboard ---------------------------------------------
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  acc_t exp_cp_q[$];
  acc_t exp_pi_q[$];
  bit   grant_log[$];
  bit   log_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor -------------------------------------------------
  int   we_cnt, oe_cnt, oein_cnt, doe_cnt, le_cnt;
  bit   prev_cp_ack, prev_pi_ack;
  acc_t e_mon;

  always @(negedge CLK) begin
    if (!RST_n) begin
      we_cnt = 0; oe_cnt = 0; oein_cnt = 0; doe_cnt = 0; le_cnt = 0;
      prev_cp_ack = 1'b0; prev_pi_ack = 1'b0;
    end else begin
      chk("inv_doe_oein", 32'(D_OE && !OE_IN_n), 32'd0);
      chk("inv_oe_drive", 32'(!RAM_OE_n && (D_OE || !OE_IN_n)), 32'd0);
      chk("inv_oe_we",    32'(!RAM_OE_n && !RAM_WE_n), 32'd0);
      if (!RAM_WE_n) we_cnt++;
      if (!RAM_OE_n) oe_cnt++;
      if (!OE_IN_n)  oein_cnt++;
      if (D_OE)      doe_cnt++;
      if (LE_OUT)    le_cnt++;
      if (CP_ACK && prev_cp_ack) chk("cp_ack_width", 32'd2, 32'd1);
      if (PI_ACK && prev_pi_ack) chk("pi_ack_width", 32'd2, 32'd1);

      if (CP_ACK && !prev_cp_ack) begin
        if (log_en) grant_log.push_back(1'b0);
        if (exp_cp_q.size() == 0) begin
          chk("cp_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e_mon = exp_cp_q.pop_front();
          chk("cp_grant_pi", 32'(GRANT_PI), 32'd0);
          chk("cp_ram_a", 32'(RAM_A), 32'(e_mon.addr));
          chk("cp_hold_strobes", 32'({RAM_OE_n, RAM_WE_n, LE_OUT, BUSY}), 32'b1101);
          if (e_mon.we) begin
            chk("cp_wr_mem", 32'(mem[e_mon.addr]), 32'(e_mon.data));
            chk("cp_wr_we_cycles", 32'(we_cnt), 32'(WR_CYCLES));
            chk("cp_wr_oein_cycles", 32'(oein_cnt), 32'(WR_CYCLES + 2));
            chk("cp_wr_no_oe", 32'(oe_cnt + doe_cnt + le_cnt), 32'd0);
          end else begin
            chk("cp_rd_latch", 32'(cp_latch), 32'(e_mon.data));
            chk("cp_rd_oe_cycles", 32'(oe_cnt), 32'(RD_CYCLES));
            chk("cp_rd_le_cycles", 32'(le_cnt), 32'(RD_CYCLES + 1));
            chk("cp_rd_no_drive", 32'(we_cnt + doe_cnt + oein_cnt), 32'd0);
          end
        end
      end

      if (PI_ACK && !prev_pi_ack) begin
        if (log_en) grant_log.push_back(1'b1);
        if (exp_pi_q.size() == 0) begin
          chk("pi_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e_mon = exp_pi_q.pop_front();
          chk("pi_grant_pi", 32'(GRANT_PI), 32'd1);
          chk("pi_ram_a", 32'(RAM_A), 32'(e_mon.addr));
          chk("pi_hold_strobes", 32'({RAM_OE_n, RAM_WE_n, LE_OUT, BUSY}), 32'b1101);
          if (e_mon.we) begin
            chk("pi_wr_mem", 32'(mem[e_mon.addr]), 32'(e_mon.data));
            chk("pi_wr_we_cycles", 32'(we_cnt), 32'(WR_CYCLES));
            chk("pi_wr_doe_cycles", 32'(doe_cnt), 32'(WR_CYCLES + 2));
            chk("pi_wr_no_oe", 32'(oe_cnt + oein_cnt + le_cnt), 32'd0);
          end else begin
            chk("pi_rdata", 32'(PI_RDATA), 32'(e_mon.data));
            chk("pi_rd_oe_cycles", 32'(oe_cnt), 32'(RD_CYCLES));
            chk("pi_rd_no_drive", 32'(we_cnt + doe_cnt + oein_cnt + le_cnt), 32'd0);
          end
        end
      end

      if (CP_ACK || PI_ACK) begin
        we_cnt = 0; oe_cnt = 0; oein_cnt = 0; doe_cnt = 0; le_cnt = 0;
      end
      prev_cp_ack = CP_ACK;
      prev_pi_ack = PI_ACK;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  // Raise a request and push the completion the reference model predicts.
  task automatic issue(input bit is_pi, input logic we, input logic [15:0] addr,
                       input logic [7:0] data);
    acc_t e;
    e.we   = we;
    e.addr = addr;
    e.data = we ? data : ref_mem[addr];
    if (we) ref_mem[addr] = data;
    if (is_pi) begin
      PI_WE = we; PI_ADDR = addr; PI_WDATA = data; PI_REQ = 1'b1;
      exp_pi_q.push_back(e);
    end else begin
      CP_WE = we; CP_ADDR = addr; cp_data = data; CP_REQ = 1'b1;
      exp_cp_q.push_back(e);
    end
  endtask

  // Wait (bounded) for the requester's ACK; lat = negedges until it is seen.
  task automatic wait_ack(input bit is_pi, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge CLK);
      if (is_pi ? PI_ACK : CP_ACK) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) chk(is_pi ? "pi_ack_timeout" : "cp_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input bit is_pi, input logic we, input logic [15:0] addr,
                           input logic [7:0] data, output int lat);
    issue(is_pi, we, addr, data);
    wait_ack(is_pi, lat);
    if (is_pi) PI_REQ = 1'b0;
    else       CP_REQ = 1'b0;
  endtask

  // ---------------- main sequence -------------------------------------------
  int lat_m, acks, busy_seen, wait_n;

  initial begin
    RST_n = 1'b0;
    CP_REQ = 1'b0; CP_WE = 1'b0; CP_ADDR = '0;
    PI_REQ = 1'b0; PI_WE = 1'b0; PI_ADDR = '0; PI_WDATA = '0;
    cp_data = 8'h00; cp_latch = 8'h00;
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 8'(a ^ (a >> 8) ^ 8'h5C);
      ref_mem[a] = 8'(a ^ (a >> 8) ^ 8'h5C);
    end
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_ram_oe_n", 32'(RAM_OE_n), 32'd1);
    chk("rst_ram_we_n", 32'(RAM_WE_n), 32'd1);
    chk("rst_oe_in_n",  32'(OE_IN_n),  32'd1);
    chk("rst_le_out",   32'(LE_OUT),   32'd0);
    chk("rst_d_oe",     32'(D_OE),     32'd0);
    chk("rst_d_out",    32'(D_OUT),    32'd0);
    chk("rst_ram_a",    32'(RAM_A),    32'd0);
    chk("rst_pi_rdata", 32'(PI_RDATA), 32'd0);
    chk("rst_acks",     32'({CP_ACK, PI_ACK}), 32'd0);
    chk("rst_busy",     32'(BUSY),     32'd0);
    chk("rst_grant_pi", 32'(GRANT_PI), 32'd0);
    RST_n = 1'b1;
    @(negedge CLK);

    // CP write through the input latch
    do_access(1'b0, 1'b1, 16'h1122, 8'hAA, lat_m);
    chk("cp_wr_latency", 32'(lat_m), 32'(WR_CYCLES + 2));
    chk("cp_wr_sram", 32'(mem[16'h1122]), 32'h00AA);
    @(negedge CLK);

    // PI write then PI read of the same location
    do_access(1'b1, 1'b1, 16'h1234, 8'h78, lat_m);
    chk("pi_wr_latency", 32'(lat_m), 32'(WR_CYCLES + 2));
    @(negedge CLK);
    do_access(1'b1, 1'b0, 16'h1234, 8'h00, lat_m);
    chk("pi_rd_latency", 32'(lat_m), 32'(RD_CYCLES + 2));
    chk("pi_rd_value", 32'(PI_RDATA), 32'h0078);
    @(negedge CLK);

    // CP read of a preloaded location into the output latch
    mem[16'hBBAA] = 8'h5A;
    ref_mem[16'hBBAA] = 8'h5A;
    do_access(1'b0, 1'b0, 16'hBBAA, 8'h00, lat_m);
    chk("cp_rd_latency", 32'(lat_m), 32'(RD_CYCLES + 2));
    chk("cp_rd_outlatch", 32'(cp_latch), 32'h005A);
    @(negedge CLK);

    // REQ held high after ACK: no second service until it is seen low
    issue(1'b0, 1'b0, 16'h0105, 8'h00);
    wait_ack(1'b0, lat_m);
    acks = 0; busy_seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (CP_ACK) acks++;
      if (BUSY) busy_seen++;
    end
    chk("held_req_acks", 32'(acks), 32'd0);
    chk("held_req_busy", 32'(busy_seen), 32'd0);
    CP_REQ = 1'b0;
    @(negedge CLK);
    do_access(1'b0, 1'b1, 16'h0106, 8'hC3, lat_m);
    chk("rearm_latency", 32'(lat_m), 32'(WR_CYCLES + 2));
    @(negedge CLK);

    // Continuous contention: grants must alternate
    grant_log.delete();
    log_en = 1'b1;
    fork
      begin
        int lc;
        for (int i = 0; i < 4; i++) begin
          do_access(1'b0, 1'(i & 1), 16'h0100 + 16'(i), 8'(8'h10 + i), lc);
          @(negedge CLK);
        end
      end
      begin
        int lp;
        for (int j = 0; j < 4; j++) begin
          do_access(1'b1, 1'(~j & 1), 16'h8100 + 16'(j), 8'(8'h20 + j), lp);
          @(negedge CLK);
        end
      end
    join
    log_en = 1'b0;
    chk("contention_grants", 32'(grant_log.size()), 32'd8);
    for (int k = 1; k < grant_log.size(); k++) begin
      chk("contention_alternate", 32'(grant_log[k] != grant_log[k-1]), 32'd1);
    end

    // Randomised mixed traffic, CP and PI in disjoint address windows
    fork
      begin
        int lc2;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          do_access(1'b0, 1'($urandom_range(0, 1)), 16'h0100 | 16'($urandom_range(0, 15)),
                    8'($urandom), lc2);
          @(negedge CLK);
        end
      end
      begin
        int lp2;
        for (int j = 0; j < 25; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          do_access(1'b1, 1'($urandom_range(0, 1)), 16'h8100 | 16'($urandom_range(0, 15)),
                    8'($urandom), lp2);
          @(negedge CLK);
        end
      end
    join
    @(negedge CLK);

    // Reset during the ACCESS phase of a CP write
    issue(1'b0, 1'b1, 16'h7F00, 8'h3C);
    wait_n = 0;
    while (RAM_WE_n !== 1'b0 && wait_n < 50) begin
      @(negedge CLK);
      wait_n++;
    end
    chk("abort_write_started", 32'(RAM_WE_n), 32'd0);
    RST_n = 1'b0;
    @(negedge CLK);
    chk("abort_strobes", 32'({RAM_OE_n, RAM_WE_n, OE_IN_n, LE_OUT, D_OE}), 32'b11100);
    chk("abort_no_ack", 32'({CP_ACK, PI_ACK, BUSY}), 32'd0);
    @(negedge CLK);
    chk("abort_no_ack_2", 32'({CP_ACK, PI_ACK}), 32'd0);
    RST_n = 1'b1;
    wait_ack(1'b0, lat_m);
    chk("resume_latency", 32'(lat_m), 32'(WR_CYCLES + 2));
    CP_REQ = 1'b0;
    repeat (3) @(negedge CLK);

    chk("cp_queue_drained", 32'(exp_cp_q.size()), 32'd0);
    chk("pi_queue_drained", 32'(exp_pi_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp_pi_sram_arbiter.md
Name: cp_pi_sram_arbiter

Overview:
- Sequences every access to the shared 64K x 8 SRAM and the shared D bus.
- Arbitrates between two requesters: the clock-port register decoder (CP) and the Raspberry Pi register decoder (PI).
- Generates RAM_A, RAM_OE_n and RAM_WE_n, the bus-latch controls LE_OUT and OE_IN_n, and the FPGA's own D-bus drive enable.
- Round-robin on conflict; one access in flight at a time; 4-phase req/ack per requester.

Parameters:
- ADDR_W, 16, SRAM address width.
- RD_CYCLES, 3, cycles RAM_OE_n is held low per read (min 1).
- WR_CYCLES, 3, cycles RAM_WE_n is held low per write (min 1).

Ports:
- CLK  in  1  system clock
- RST_n  in  1  synchronous active-low reset
- CP_REQ  in  1  CP access request, level, held until CP_ACK
- CP_WE  in  1  CP access is write (data comes from CP_Data via input latch)
- CP_ADDR  in  ADDR_W  CP SRAM address
- CP_ACK  out  1  one-cycle completion pulse to CP
- PI_REQ  in  1  PI access request, level, held until PI_ACK
- PI_WE  in  1  PI access is write
- PI_ADDR  in  ADDR_W  PI SRAM address
- PI_WDATA  in  8  PI write data
- PI_ACK  out  1  one-cycle completion pulse to PI
- PI_RDATA  out  8  PI read data, valid from PI_ACK until next PI read completes
- D_IN  in  8  sampled D bus
- D_OUT  out  8  FPGA drive value for D
- D_OE  out  1  FPGA drives D when 1
- RAM_A  out  ADDR_W  SRAM address
- RAM_OE_n  out  1  SRAM output enable
- RAM_WE_n  out  1  SRAM write enable
- LE_OUT  out  1  output latch (towards CP) enable; transparent when 1, latches on fall
- OE_IN_n  out  1  input latch (CP_Data -> D) output enable
- GRANT_PI  out  1  1 while the current/last access belongs to PI
- BUSY  out  1  1 in any state other than IDLE

Behaviour:
- Reset (RST_n low at a CLK edge, any state):
  - RAM_OE_n=1, RAM_WE_n=1, OE_IN_n=1, LE_OUT=0, D_OE=0, D_OUT=0, RAM_A=0, PI_RDATA=0.
  - CP_ACK=0, PI_ACK=0, BUSY=0, GRANT_PI=0.
  - FSM goes to IDLE, round-robin pointer set so CP wins the first tie, both armed flags set to 1.
  - An access aborted by reset gets no ACK.
- FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE. All outputs are registered.
- Arming:
  - A requester is eligible only if its REQ=1 and its armed flag is 1.
  - The armed flag clears when that requester's ACK is issued and sets again when its REQ is sampled 0.
  - So a REQ held high after ACK is never served twice.
- IDLE:
  - One eligible requester: grant it.
  - Both eligible: grant the one not granted last, then update the pointer.
  - On grant: capture address/WE (and PI_WDATA), drive RAM_A, set GRANT_PI, set BUSY, go to SETUP.
- SETUP (1 cycle):
  - Strobes high, address stable.
  - CP write: OE_IN_n=0.
  - PI write: D_OE=1, D_OUT=captured data.
  - Reads: D_OE=0, OE_IN_n=1.
  - CP read: LE_OUT=1.
- ACCESS:
  - Read: RAM_OE_n=0 for RD_CYCLES cycles. Write: RAM_WE_n=0 for WR_CYCLES cycles.
  - Write-data drive from SETUP is held throughout.
  - On the last read cycle: PI read latches D_IN into PI_RDATA; CP read keeps LE_OUT=1.
- HOLD (1 cycle):
  - RAM_OE_n=RAM_WE_n=1, LE_OUT=0 (output latch captures read data).
  - Write data drive (OE_IN_n=0 / D_OE=1) held this cycle for hold time, released when leaving HOLD.
  - ACK of the granted requester =1 for exactly this cycle; its armed flag clears. Then IDLE.
- Latency: with the request first eligible in IDLE at edge k, ACK is high in cycle k+2+N (N = RD_CYCLES or WR_CYCLES). Defaults give k+5. Min spacing between grants is N+3 cycles.
- Contention invariants (must hold every cycle):
  - Never D_OE=1 and OE_IN_n=0 together.
  - Never RAM_OE_n=0 with D_OE=1 or OE_IN_n=0.
  - Never RAM_OE_n=0 and RAM_WE_n=0 together.
- Request changes during SETUP/ACCESS/HOLD: captured values are used. The other requester waits; no starvation (at most one foreign access between two of its own).
- Address is not modified by this block; increment is the register decoder's job.

Test Plan:
- CP write: CP_REQ=1, CP_WE=1, CP_ADDR=0x1122, input latch presenting 0xAA -> RAM_A=0x1122, OE_IN_n low SETUP..HOLD, RAM_WE_n low 3 cycles, CP_ACK pulse at k+5, SRAM[0x1122]=0xAA.
- PI write then PI read: write 0x1234=0x78 then read 0x1234 -> D_OE/D_OUT=0x78 around WE, RAM_OE_n low 3 cycles on the read, PI_RDATA=0x78 at PI_ACK.
- CP read 0xBBAA preloaded 0x5A -> LE_OUT high SETUP..ACCESS, falls in HOLD; output latch holds 0x5A; D_OE stays 0.
- Simultaneous CP_REQ and PI_REQ held continuously (both re-armed by toggling after each ACK) -> grants alternate CP, PI, CP, PI; no overlapping strobes; contention invariants checked every cycle.
- REQ held high 20 cycles after ACK -> exactly one ACK; a new access only after REQ is seen low.
- RST_n low during ACCESS of a write -> next edge all strobes inactive, D_OE=0, OE_IN_n=1, no ACK; after release, the pending CP_REQ (re-armed) is served normally.
